dea_tx_framer: RTL
==================

// Module: dea_tx_framer
// PURPOSE
//  Downstream stage of the XOR encryption engine. Buffers encrypted result bytes in a FIFO and frames them.
//  Each frame goes to the PC over UART_Sender as a length header, then the payload, then an optional checksum.
//  Separates encryption rate from UART rate, so the engine never stalls on Tx_Busy.
// PARAMETERS
//  DEPTH    128  FIFO entries; must be a power of 2 and >= MAX_LEN
//  AW       7    log2(DEPTH)
//  MAX_LEN  100  largest accepted frame_len (matches the 100-byte data buffer)
// PORTS
//  Clk_100M     in   1     system clock, 100 MHz
//  Reset        in   1     synchronous, active-high
//  frame_start  in   1     1-cycle pulse: begin a frame of frame_len bytes
//  frame_len    in   8     payload byte count, sampled with frame_start
//  wr_valid     in   1     result byte valid
//  wr_data      in   8     encrypted result byte
//  wr_ready     out  1     FIFO not full
//  Tx_Data      out  8     byte to UART_Sender
//  Tx_Send      out  1     send request to UART_Sender
//  Tx_Busy      in   1     UART_Sender busy
//  busy         out  1     frame in progress (state != IDLE)
//  frame_done   out  1     1-cycle pulse after the last byte of a frame drains
//  err          out  1     sticky: overflow, oversize length, or frame_start while busy
//  level        out  AW+1  FIFO occupancy
// BEHAVIOUR
//  Reset (sync, 1 cycle):
//   - state=IDLE; FIFO emptied; all outputs 0; wr_ready=1.
//   - Applies mid-frame too: Tx_Send drops the next edge; the partial frame is discarded.
//  FIFO:
//   - First-word-fall-through. Write when wr_valid & wr_ready.
//   - Write while full: byte dropped, err<=1.
//   - Simultaneous read and write when full: write is still refused (wr_ready is registered from level).
//  Byte send sub-handshake (SEND -> ACKW -> DRAIN), used for every byte:
//   - SEND: wait for ~Tx_Busy; drive Tx_Data and Tx_Send=1.
//   - ACKW: hold Tx_Send=1 until Tx_Busy=1, then Tx_Send<=0.
//   - DRAIN: wait for Tx_Busy=0, then fetch the next byte.
//   - A byte is never re-sent; Tx_Data is stable throughout SEND and ACKW.
//  Frame FSM (binary-encoded, states in dea_pkg):
//   - IDLE: on frame_start, latch len=frame_len and clear remaining count -> HDR.
//     If frame_len > MAX_LEN: err<=1 and the frame is ignored (stay IDLE).
//   - HDR: send the len byte. Then go to PAY if len!=0, else to CSUM (or FIN without the feature).
//   - PAY: if FIFO empty, wait; no timeout.
//     Otherwise pop the head into Tx_Data on entry to SEND and decrement remaining.
//     When remaining reaches 0 after DRAIN -> CSUM / FIN.
//   - CSUM: send the running XOR of the payload bytes.
//   - FIN: frame_done=1 for one cycle -> IDLE.
//  Timing:
//   - frame_start while busy is ignored and sets err.
//   - Latency: Tx_Send rises 2 cycles after frame_start when Tx_Busy=0.
//   - Bytes written before frame_start are kept and belong to the next frame.
//   - Bytes beyond len stay in the FIFO for the following frame.
//  Arithmetic:
//   - 8-bit remaining counter; len=0 is legal and gives a header-only frame.
//   - FIFO pointers are AW+1 bits and wrap modulo 2*DEPTH; full/empty are decided by the MSB compare.
// CONFIGURATION
//  DEA_TX_CHECKSUM_EN defined:
//   - After the payload, send 1 trailer byte = XOR of all payload bytes (0x00 when len=0).
//   - Frame = len+2 bytes.
//  Not defined:
//   - No CSUM state and no accumulator logic; frame = len+1 bytes.
// STRUCTURE
//  - dea_pkg: state encodings (IDLE, HDR, PAY, CSUM, FIN; SEND, ACKW, DRAIN), DEA_MAX_LEN=100, header/checksum widths.
//  - Sub-module dea_byte_fifo (DEPTH, AW): FWFT synchronous FIFO with level output.
//  - The frame FSM, send sub-FSM and checksum stay in dea_tx_framer.
//  - Bench uses a UART_Sender behavioural model: Tx_Busy rises 1 cycle after Tx_Send and stays high 20 cycles.
// TESTING
//  1. Basic frame (checksum on):
//     write 0x41,0x42,0x43; frame_start, len=3
//     -> Tx bytes 0x03,0x41,0x42,0x43,0x40; one frame_done pulse; err=0.
//  2. Zero length: frame_start, len=0
//     -> Tx 0x00 (+0x00 with checksum); frame_done; FIFO untouched.
//  3. Payload underrun: frame_start, len=2, FIFO empty
//     -> header sent, FSM waits in PAY; write 0x10 after 100 cycles, then 0x20
//     -> Tx 0x02,0x10,0x20,(0x30).
//  4. Overflow: DEPTH+1 writes with no frame
//     -> level=DEPTH, wr_ready=0, err=1, last byte absent.
//     Oversize frame_len=101 -> err=1, no Tx_Send.
//  5. Reset mid-payload after 2 of 5 bytes
//     -> next cycle Tx_Send=0, busy=0, level=0.
//     New frame len=1 with data 0x7E -> Tx 0x01,0x7E,(0x7E).
//  6. frame_start while busy
//     -> ignored, err=1, the current frame completes byte-exact.

Source files
------------

// File: rtl/dea_pkg.sv
// Shared encodings and limits for the DEA transmit framer.
// Define DEA_TX_CHECKSUM_EN to append the XOR checksum trailer byte.
package dea_pkg;

  localparam int DEA_MAX_LEN = 100;
  localparam int DEA_HDR_W   = 8;
  localparam int DEA_CSUM_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CSUM = 3'd3,
    ST_FIN  = 3'd4
  } frame_state_e;

  typedef enum logic [1:0] {
    BS_SEND  = 2'd0,
    BS_ACKW  = 2'd1,
    BS_DRAIN = 2'd2
  } byte_state_e;

  // Where a frame goes once its payload (or empty payload) is finished.
  function automatic frame_state_e post_payload_state();
`ifdef DEA_TX_CHECKSUM_EN
    return ST_CSUM;
`else
    return ST_FIN;
`endif
  endfunction

endpackage

// File: rtl/dea_byte_fifo.sv
// First-word-fall-through byte FIFO with registered occupancy and ready.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module dea_byte_fifo #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_valid_i,
  input  logic [7:0]    wr_data_i,
  output logic          wr_ready_o,
  input  logic          rd_i,
  output logic [7:0]    rd_data_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d, level_q;
  logic        wr_ready_q, wr_en_s, rd_en_s;

  function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  always_comb begin
    wr_en_s = wr_valid_i && wr_ready_q;
    rd_en_s = rd_i && (wptr_q != rptr_q);
    wptr_d  = wptr_q + {{AW{1'b0}}, wr_en_s};
    rptr_d  = rptr_q + {{AW{1'b0}}, rd_en_s};
  end

  // Ready is derived from the next pointers, so a write in the same cycle as a
  // read while full is still refused.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= wptr_d - rptr_d;
      wr_ready_q <= !ptr_full(wptr_d, rptr_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o    = (wptr_q == rptr_q);
  assign wr_ready_o = wr_ready_q;
  assign level_o    = level_q;

endmodule

// File: rtl/dea_tx_framer.sv
// Frames buffered encrypted bytes as header, payload and optional checksum for UART_Sender.
// Define DEA_TX_CHECKSUM_EN to append the XOR-of-payload trailer byte.
module dea_tx_framer
  import dea_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int AW      = 7,
  parameter int MAX_LEN = DEA_MAX_LEN
) (
  input  logic          Clk_100M,
  input  logic          Reset,
  input  logic          frame_start,
  input  logic [7:0]    frame_len,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic [7:0]    Tx_Data,
  output logic          Tx_Send,
  input  logic          Tx_Busy,
  output logic          busy,
  output logic          frame_done,
  output logic          err,
  output logic [AW:0]   level
);

  frame_state_e          st_q;
  byte_state_e           bs_q;
  logic                  pend_q;
  logic [DEA_HDR_W-1:0]  len_q;
  logic [7:0]            rem_q;
  logic [7:0]            tx_data_q;
  logic                  tx_send_q, busy_q, frame_done_q, err_q;
`ifdef DEA_TX_CHECKSUM_EN
  logic [DEA_CSUM_W-1:0] csum_q;
`endif

  logic       fifo_rd_s, fifo_empty_s;
  logic [7:0] fifo_head_s;

  dea_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i      (Clk_100M),
    .rst_i      (Reset),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .rd_i       (fifo_rd_s),
    .rd_data_o  (fifo_head_s),
    .empty_o    (fifo_empty_s),
    .level_o    (level)
  );

  // The head is popped in the same cycle it is latched into Tx_Data.
  assign fifo_rd_s = (st_q == ST_PAY) && !pend_q && !fifo_empty_s;

  // Frame FSM with the per-byte SEND/ACKW/DRAIN handshake nested inside it;
  // pend_q marks that Tx_Data holds a byte not yet fully handed over.
  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      st_q         <= ST_IDLE;
      bs_q         <= BS_SEND;
      pend_q       <= 1'b0;
      len_q        <= 8'd0;
      rem_q        <= 8'd0;
      tx_data_q    <= 8'd0;
      tx_send_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef DEA_TX_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      if ((wr_valid && !wr_ready) || (frame_start && busy_q)) begin
        err_q <= 1'b1;
      end
      case (st_q)
        ST_IDLE: begin
          if (frame_start) begin
            if (frame_len > 8'(MAX_LEN)) begin
              err_q <= 1'b1;
            end else begin
              len_q     <= frame_len;
              rem_q     <= 8'd0;
              tx_data_q <= frame_len;
              pend_q    <= 1'b1;
              bs_q      <= BS_SEND;
              busy_q    <= 1'b1;
              st_q      <= ST_HDR;
`ifdef DEA_TX_CHECKSUM_EN
              csum_q    <= 8'd0;
`endif
            end
          end
        end
        ST_HDR, ST_PAY, ST_CSUM: begin
          if (!pend_q) begin
            if (fifo_rd_s) begin
              tx_data_q <= fifo_head_s;
              rem_q     <= rem_q - 8'd1;
              pend_q    <= 1'b1;
              bs_q      <= BS_SEND;
`ifdef DEA_TX_CHECKSUM_EN
              csum_q    <= csum_q ^ fifo_head_s;
            end else if (st_q == ST_CSUM) begin
              tx_data_q <= csum_q;
              pend_q    <= 1'b1;
              bs_q      <= BS_SEND;
`endif
            end
          end else begin
            case (bs_q)
              BS_SEND: begin
                if (!Tx_Busy) begin
                  tx_send_q <= 1'b1;
                  bs_q      <= BS_ACKW;
                end
              end
              BS_ACKW: begin
                if (Tx_Busy) begin
                  tx_send_q <= 1'b0;
                  bs_q      <= BS_DRAIN;
                end
              end
              BS_DRAIN: begin
                if (!Tx_Busy) begin
                  pend_q <= 1'b0;
                  bs_q   <= BS_SEND;
                  if (st_q == ST_HDR) begin
                    rem_q <= len_q;
                    st_q  <= (len_q != 8'd0) ? ST_PAY : post_payload_state();
                  end else if (st_q == ST_PAY) begin
                    if (rem_q == 8'd0) begin
                      st_q <= post_payload_state();
                    end
                  end else begin
                    st_q <= ST_FIN;
                  end
                end
              end
              default: begin
                tx_send_q <= 1'b0;
                bs_q      <= BS_SEND;
              end
            endcase
          end
        end
        ST_FIN: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          st_q         <= ST_IDLE;
        end
        default: begin
          tx_send_q <= 1'b0;
          pend_q    <= 1'b0;
          busy_q    <= 1'b0;
          st_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign Tx_Data    = tx_data_q;
  assign Tx_Send    = tx_send_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
